// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite crossbar slice.
// Contents:
//   RESP_*   - AXI response encodings used by the crossbar.
//   rstate_t - read-path FSM states  (R_IDLE, R_DATA).
//   wstate_t - write-path FSM states (W_IDLE, W_DATA, W_RESP).
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

endpackage

// File: rtl/axi_lite_addr_dec.sv
// Address decoder: compares an address against a per-slave BASE/MASK table.
// Ports:
//   addr - address to decode
//   idx  - index of the matching slave (lowest index wins on overlap)
//   miss - 1 when no slave matches; idx is 0 in that case
module axi_lite_addr_dec #(
  parameter int                    NSLV     = 3,
  parameter int                    AW       = 32,
  parameter logic [NSLV*AW-1:0]    SLV_BASE = {32'h10001000, 32'h10000000, 32'h80000000},
  parameter logic [NSLV*AW-1:0]    SLV_MASK = {32'hFFFFF000, 32'hFFFFFFF0, 32'hFF000000},
  localparam int                   IW       = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic          miss
);

  // Scan from the highest index down so that the lowest matching index is
  // the last assignment and therefore wins.
  always_comb begin
    idx  = '0;
    miss = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        idx  = IW'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_xbar_n.sv
// 1-master to NSLV-slave AXI4-Lite crossbar.
// Read and write paths are independent FSMs, each with at most one
// transaction outstanding. Addresses hitting no slave are answered
// internally with DECERR.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_ar*/in_r*        - upstream read address / read data channels
//   in_aw*/in_w*/in_b*  - upstream write address / data / response channels
//   m_ar*/m_r*          - per-slave read channels (bit/slot i = slave i)
//   m_aw*/m_w*/m_b*     - per-slave write channels (bit/slot i = slave i)
//   dbg_rstate          - current read FSM state
//   dbg_wstate          - current write FSM state
//
// Handshake semantics (all channels, both sides): a transfer happens on a
// rising clk edge where valid and ready are both 1. A valid, once raised,
// stays high with stable payload until that transfer; ready may depend
// combinationally on valid. Payload outputs toward upstream read 0 while
// their valid is 0.
module axi_lite_xbar_n
  import axi_lite_pkg::*;
#(
  parameter int                 NSLV     = 3,
  parameter int                 AW       = 32,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h10001000, 32'h10000000, 32'h80000000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFFF000, 32'hFFFFFFF0, 32'hFF000000}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // upstream read
  input  logic                   in_arvalid,
  output logic                   in_arready,
  input  logic [AW-1:0]          in_araddr,
  output logic                   in_rvalid,
  input  logic                   in_rready,
  output logic [DW-1:0]          in_rdata,
  output logic [1:0]             in_rresp,
  // upstream write
  input  logic                   in_awvalid,
  output logic                   in_awready,
  input  logic [AW-1:0]          in_awaddr,
  input  logic                   in_wvalid,
  output logic                   in_wready,
  input  logic [DW-1:0]          in_wdata,
  input  logic [DW/8-1:0]        in_wstrb,
  output logic                   in_bvalid,
  input  logic                   in_bready,
  output logic [1:0]             in_bresp,
  // downstream read
  output logic [NSLV-1:0]        m_arvalid,
  input  logic [NSLV-1:0]        m_arready,
  output logic [NSLV*AW-1:0]     m_araddr,
  input  logic [NSLV-1:0]        m_rvalid,
  output logic [NSLV-1:0]        m_rready,
  input  logic [NSLV*DW-1:0]     m_rdata,
  input  logic [NSLV*2-1:0]      m_rresp,
  // downstream write
  output logic [NSLV-1:0]        m_awvalid,
  input  logic [NSLV-1:0]        m_awready,
  output logic [NSLV*AW-1:0]     m_awaddr,
  output logic [NSLV-1:0]        m_wvalid,
  input  logic [NSLV-1:0]        m_wready,
  output logic [NSLV*DW-1:0]     m_wdata,
  output logic [NSLV*DW/8-1:0]   m_wstrb,
  input  logic [NSLV-1:0]        m_bvalid,
  output logic [NSLV-1:0]        m_bready,
  input  logic [NSLV*2-1:0]      m_bresp,
  // debug
  output rstate_t                dbg_rstate,
  output wstate_t                dbg_wstate
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // ---------------------------------------------------------------- decode
  logic [IW-1:0] ar_idx, aw_idx;
  logic          ar_miss, aw_miss;

  axi_lite_addr_dec #(
    .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_ar_dec (
    .addr(in_araddr), .idx(ar_idx), .miss(ar_miss)
  );

  axi_lite_addr_dec #(
    .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_aw_dec (
    .addr(in_awaddr), .idx(aw_idx), .miss(aw_miss)
  );

  // Payloads are broadcast; only the selected slave sees a valid.
  assign m_araddr = {NSLV{in_araddr}};
  assign m_awaddr = {NSLV{in_awaddr}};
  assign m_wdata  = {NSLV{in_wdata}};
  assign m_wstrb  = {NSLV{in_wstrb}};

  // ------------------------------------------------------------- read path
  rstate_t       rstate, rstate_nxt;
  logic [IW-1:0] rt;
  logic          rmiss;
  logic          ar_fire;

  always_comb begin
    m_arvalid  = '0;
    m_rready   = '0;
    in_arready = 1'b0;
    in_rvalid  = 1'b0;
    in_rdata   = '0;
    in_rresp   = '0;
    ar_fire    = 1'b0;
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE: begin
        if (ar_miss) begin
          in_arready = 1'b1;
        end else begin
          m_arvalid[ar_idx] = in_arvalid;
          in_arready        = m_arready[ar_idx];
        end
        ar_fire = in_arvalid && in_arready;
        if (ar_fire) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        if (rmiss) begin
          in_rvalid = 1'b1;
          in_rresp  = RESP_DECERR;
        end else begin
          in_rvalid    = m_rvalid[rt];
          m_rready[rt] = in_rready;
          if (in_rvalid) begin
            in_rdata = m_rdata[rt*DW +: DW];
            in_rresp = m_rresp[rt*2 +: 2];
          end
        end
        if (in_rvalid && in_rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rt     <= '0;
      rmiss  <= 1'b0;
    end else begin
      rstate <= rstate_nxt;
      if (ar_fire) begin
        rt    <= ar_idx;
        rmiss <= ar_miss;
      end
    end
  end

  // ------------------------------------------------------------ write path
  wstate_t       wstate, wstate_nxt;
  logic [IW-1:0] wt;
  logic          wmiss;
  logic          aw_fire;

  always_comb begin
    m_awvalid  = '0;
    m_wvalid   = '0;
    m_bready   = '0;
    in_awready = 1'b0;
    in_wready  = 1'b0;
    in_bvalid  = 1'b0;
    in_bresp   = '0;
    aw_fire    = 1'b0;
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_miss) begin
          in_awready = 1'b1;
        end else begin
          m_awvalid[aw_idx] = in_awvalid;
          in_awready        = m_awready[aw_idx];
        end
        aw_fire = in_awvalid && in_awready;
        if (aw_fire) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        // On a miss the write data is swallowed without reaching any slave.
        if (wmiss) begin
          in_wready = 1'b1;
        end else begin
          m_wvalid[wt] = in_wvalid;
          in_wready    = m_wready[wt];
        end
        if (in_wvalid && in_wready) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (wmiss) begin
          in_bvalid = 1'b1;
          in_bresp  = RESP_DECERR;
        end else begin
          in_bvalid    = m_bvalid[wt];
          m_bready[wt] = in_bready;
          if (in_bvalid) in_bresp = m_bresp[wt*2 +: 2];
        end
        if (in_bvalid && in_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate <= W_IDLE;
      wt     <= '0;
      wmiss  <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      if (aw_fire) begin
        wt    <= aw_idx;
        wmiss <= aw_miss;
      end
    end
  end

  assign dbg_rstate = rstate;
  assign dbg_wstate = wstate;

endmodule

// File: tb/tb_axi_lite_xbar_n.sv
module tb_axi_lite_xbar_n;
  import axi_lite_pkg::*;

  localparam int NSLV = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  in_arvalid, in_arready, in_rvalid, in_rready;
  logic [AW-1:0]         in_araddr;
  logic [DW-1:0]         in_rdata;
  logic [1:0]            in_rresp;
  logic                  in_awvalid, in_awready, in_wvalid, in_wready;
  logic                  in_bvalid, in_bready;
  logic [AW-1:0]         in_awaddr;
  logic [DW-1:0]         in_wdata;
  logic [DW/8-1:0]       in_wstrb;
  logic [1:0]            in_bresp;
  logic [NSLV-1:0]       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NSLV*AW-1:0]    m_araddr, m_awaddr;
  logic [NSLV*DW-1:0]    m_rdata, m_wdata;
  logic [NSLV*2-1:0]     m_rresp, m_bresp;
  logic [NSLV-1:0]       m_awvalid, m_awready, m_wvalid, m_wready;
  logic [NSLV-1:0]       m_bvalid, m_bready;
  logic [NSLV*DW/8-1:0]  m_wstrb;
  rstate_t               dbg_rstate;
  wstate_t               dbg_wstate;

  axi_lite_xbar_n dut (
    .clk(clk), .rst_n(rst_n),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .dbg_rstate(dbg_rstate), .dbg_wstate(dbg_wstate)
  );

  // ------------------------------------------------------------- scoring
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW*NSLV-1:0] act,
                     input logic [DW*NSLV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle slaves present a recognisable non-zero pattern so that a wrong
  // routing choice shows up as wrong data.
  localparam logic [NSLV*DW-1:0] RDATA_IDLE = {32'hBAD00002, 32'hBAD00001, 32'hBAD00000};

  // --------------------------------------------------------- vector table
  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;      // slave read data or upstream write data
    logic [DW/8-1:0] strb;
    logic [1:0]      sresp;     // response the slave returns
    int              wait_cyc;  // slave response delay in cycles
    logic [NSLV-1:0] exp_sel;   // expected one-hot slave select (0 = miss)
    logic [1:0]      exp_resp;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  // --------------------------------------------------------- driver tasks
  task automatic run_read(input vec_t v);
    logic [NSLV-1:0] sel;
    @(negedge clk);
    in_araddr = v.addr; in_arvalid = 1'b1; in_rready = 1'b1;
    #1;
    sel = m_arvalid;
    chk("rd_sel", sel, v.exp_sel);
    chk("rd_arready", in_arready, 1'b1);
    chk("rd_araddr_bcast", m_araddr, {NSLV{v.addr}});
    @(negedge clk);
    in_arvalid = 1'b0; in_araddr = '0;
    if (v.exp_sel == '0) begin
      #1;
      chk("rd_miss_rvalid", in_rvalid, 1'b1);
      chk("rd_miss_rresp", in_rresp, RESP_DECERR);
      chk("rd_miss_rdata", in_rdata, '0);
      chk("rd_miss_no_arvalid", m_arvalid, '0);
    end else begin
      for (int k = 0; k < v.wait_cyc; k++) begin
        #1;
        chk("rd_wait_rvalid", in_rvalid, 1'b0);
        chk("rd_wait_rdata", in_rdata, '0);
        chk("rd_wait_arvalid", m_arvalid, '0);
        @(negedge clk);
      end
      for (int i = 0; i < NSLV; i++) begin
        if (sel[i]) begin
          m_rdata[i*DW +: DW] = v.data;
          m_rresp[i*2 +: 2]   = v.sresp;
        end
      end
      m_rvalid = sel;
      #1;
      chk("rd_rvalid", in_rvalid, 1'b1);
      chk("rd_rdata", in_rdata, v.exp_rdata);
      chk("rd_rresp", in_rresp, v.exp_resp);
      chk("rd_rready_route", m_rready, v.exp_sel);
    end
    @(posedge clk);
    @(negedge clk);
    m_rvalid = '0; m_rdata = RDATA_IDLE; m_rresp = '0; in_rready = 1'b0;
    #1;
    chk("rd_done_rvalid", in_rvalid, 1'b0);
    chk("rd_done_state", dbg_rstate, R_IDLE);
  endtask

  task automatic run_write(input vec_t v);
    logic [NSLV-1:0] sel;
    @(negedge clk);
    in_awaddr = v.addr; in_awvalid = 1'b1;
    in_wdata = v.data; in_wstrb = v.strb; in_wvalid = 1'b1; in_bready = 1'b1;
    #1;
    sel = m_awvalid;
    chk("wr_sel", sel, v.exp_sel);
    chk("wr_awready", in_awready, 1'b1);
    chk("wr_idle_wready", in_wready, 1'b0);
    chk("wr_idle_wvalid", m_wvalid, '0);
    @(negedge clk);
    in_awvalid = 1'b0; in_awaddr = '0;
    #1;
    chk("wr_data_wvalid", m_wvalid, v.exp_sel);
    chk("wr_data_wready", in_wready, 1'b1);
    chk("wr_wdata_bcast", m_wdata, {NSLV{v.data}});
    chk("wr_wstrb_bcast", m_wstrb, {NSLV{v.strb}});
    @(negedge clk);
    in_wvalid = 1'b0; in_wdata = '0; in_wstrb = '0;
    if (v.exp_sel == '0) begin
      #1;
      chk("wr_miss_bvalid", in_bvalid, 1'b1);
      chk("wr_miss_bresp", in_bresp, RESP_DECERR);
    end else begin
      for (int k = 0; k < v.wait_cyc; k++) begin
        #1;
        chk("wr_wait_bvalid", in_bvalid, 1'b0);
        chk("wr_wait_bresp", in_bresp, 2'b00);
        @(negedge clk);
      end
      for (int i = 0; i < NSLV; i++)
        if (sel[i]) m_bresp[i*2 +: 2] = v.sresp;
      m_bvalid = sel;
      #1;
      chk("wr_bvalid", in_bvalid, 1'b1);
      chk("wr_bresp", in_bresp, v.exp_resp);
      chk("wr_bready_route", m_bready, v.exp_sel);
    end
    @(posedge clk);
    @(negedge clk);
    m_bvalid = '0; m_bresp = '0; in_bready = 1'b0;
    #1;
    chk("wr_done_bvalid", in_bvalid, 1'b0);
    chk("wr_done_state", dbg_wstate, W_IDLE);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    in_arvalid = 0; in_araddr = '0; in_rready = 0;
    in_awvalid = 0; in_awaddr = '0; in_wvalid = 0; in_wdata = '0; in_wstrb = '0;
    in_bready = 0;
    m_arready = '1; m_awready = '1; m_wready = '1;
    m_rvalid = '0; m_rdata = RDATA_IDLE; m_rresp = '0;
    m_bvalid = '0; m_bresp = '0;

    //          wr   addr           data           strb    sresp  wait sel     resp   rdata
    vecs[0] = '{1'b0, 32'h80000010, 32'hDEADBEEF, 4'h0, 2'b00, 3, 3'b001, 2'b00, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h10000000, 32'h00000041, 4'h1, 2'b00, 1, 3'b010, 2'b00, 32'h0};
    vecs[2] = '{1'b0, 32'h20000000, 32'h11111111, 4'h0, 2'b00, 0, 3'b000, 2'b11, 32'h0};
    vecs[3] = '{1'b1, 32'h20000000, 32'h22222222, 4'hF, 2'b00, 0, 3'b000, 2'b11, 32'h0};
    vecs[4] = '{1'b0, 32'h10001004, 32'h12345678, 4'h0, 2'b10, 0, 3'b100, 2'b10, 32'h12345678};
    vecs[5] = '{1'b0, 32'h1000000C, 32'hCAFEF00D, 4'h0, 2'b00, 2, 3'b010, 2'b00, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 32'h10000010, 32'h33333333, 4'h0, 2'b00, 0, 3'b000, 2'b11, 32'h0};
    vecs[7] = '{1'b1, 32'h80FFFFFC, 32'hA5A5A5A5, 4'hF, 2'b00, 1, 3'b001, 2'b00, 32'h0};
    vecs[8] = '{1'b1, 32'h10001FFC, 32'h0000BEEF, 4'hC, 2'b10, 0, 3'b100, 2'b10, 32'h0};
    vecs[9] = '{1'b0, 32'h7FFFFFFC, 32'h44444444, 4'h0, 2'b00, 0, 3'b000, 2'b11, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state: address 0 decodes as a miss, so address readies are 1.
    chk("rst_rvalid", in_rvalid, 1'b0);
    chk("rst_bvalid", in_bvalid, 1'b0);
    chk("rst_wready", in_wready, 1'b0);
    chk("rst_arready", in_arready, 1'b1);
    chk("rst_awready", in_awready, 1'b1);
    chk("rst_m_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, '0);
    chk("rst_rstate", dbg_rstate, R_IDLE);
    chk("rst_wstate", dbg_wstate, W_IDLE);

    for (int n = 0; n < NVEC; n++) begin
      if (vecs[n].wr) run_write(vecs[n]);
      else            run_read(vecs[n]);
    end

    // Concurrent AR to slave2 and AW to slave0; B completes before R.
    @(negedge clk);
    in_araddr = 32'h10001000; in_arvalid = 1'b1;
    in_awaddr = 32'h80000000; in_awvalid = 1'b1;
    in_wdata = 32'h0000FEED; in_wstrb = 4'hF; in_wvalid = 1'b1;
    #1;
    chk("cc_arvalid", m_arvalid, 3'b100);
    chk("cc_awvalid", m_awvalid, 3'b001);
    chk("cc_arready", in_arready, 1'b1);
    chk("cc_awready", in_awready, 1'b1);
    @(negedge clk);
    in_arvalid = 1'b0; in_awvalid = 1'b0;
    #1;
    chk("cc_rstate", dbg_rstate, R_DATA);
    chk("cc_wvalid", m_wvalid, 3'b001);
    @(negedge clk);
    in_wvalid = 1'b0;
    m_bvalid = 3'b001; m_bresp = '0; in_bready = 1'b1;
    #1;
    chk("cc_bvalid", in_bvalid, 1'b1);
    chk("cc_bresp", in_bresp, RESP_OKAY);
    chk("cc_rvalid_early", in_rvalid, 1'b0);
    @(negedge clk);
    m_bvalid = '0; in_bready = 1'b0;
    m_rdata[2*DW +: DW] = 32'h5A5A0002; m_rresp[2*2 +: 2] = RESP_OKAY;
    m_rvalid = 3'b100; in_rready = 1'b1;
    #1;
    chk("cc_wstate", dbg_wstate, W_IDLE);
    chk("cc_rvalid", in_rvalid, 1'b1);
    chk("cc_rdata", in_rdata, 32'h5A5A0002);
    @(negedge clk);
    m_rvalid = '0; m_rdata = RDATA_IDLE; in_rready = 1'b0;
    #1;
    chk("cc_rdone", dbg_rstate, R_IDLE);

    // Upstream R backpressure with a second AR pending.
    @(negedge clk);
    in_araddr = 32'h80000000; in_arvalid = 1'b1;
    @(negedge clk);
    in_araddr = 32'h10000000;
    m_rdata[0 +: DW] = 32'h13579BDF; m_rvalid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rvalid", in_rvalid, 1'b1);
      chk("bp_rdata", in_rdata, 32'h13579BDF);
      chk("bp_m_rready", m_rready, '0);
      chk("bp_arready", in_arready, 1'b0);
      chk("bp_arvalid", m_arvalid, '0);
      @(negedge clk);
    end
    in_rready = 1'b1;
    #1;
    chk("bp_m_rready_on", m_rready, 3'b001);
    @(negedge clk);
    m_rvalid = '0; m_rdata = RDATA_IDLE; in_rready = 1'b0;
    #1;
    chk("bp_next_arvalid", m_arvalid, 3'b010);
    chk("bp_next_arready", in_arready, 1'b1);
    @(negedge clk);
    in_arvalid = 1'b0; in_araddr = '0;
    m_rdata[1*DW +: DW] = 32'h00001111; m_rvalid = 3'b010; in_rready = 1'b1;
    #1;
    chk("bp_next_rdata", in_rdata, 32'h00001111);
    @(negedge clk);
    m_rvalid = '0; m_rdata = RDATA_IDLE; in_rready = 1'b0;
    #1;
    chk("bp_done", dbg_rstate, R_IDLE);

    // Reset while the write FSM waits in W_DATA.
    m_wready = '0;
    @(negedge clk);
    in_awaddr = 32'h10000000; in_awvalid = 1'b1;
    @(negedge clk);
    in_awvalid = 1'b0; in_awaddr = '0;
    in_wdata = 32'h99; in_wstrb = 4'h1; in_wvalid = 1'b1;
    #1;
    chk("rs_wstate_data", dbg_wstate, W_DATA);
    chk("rs_wvalid_pre", m_wvalid, 3'b010);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs_wvalid_post", m_wvalid, '0);
    chk("rs_awvalid_post", m_awvalid, '0);
    chk("rs_wstate_idle", dbg_wstate, W_IDLE);
    chk("rs_wready", in_wready, 1'b0);
    in_wvalid = 1'b0; in_wdata = '0; in_wstrb = '0;
    m_wready = '1;
    run_write(vecs[1]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no end expected end before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar_n.md
Name: axi_lite_xbar_n

Overview:
- Parametrised 1-master to NSLV-slave AXI4-Lite crossbar. It sits between the core's LSU/IFU arbiter and the memory and peripheral slaves (SRAM, UART, CLINT, and others).
- Read and write paths are independent FSMs, so one read and one write may be outstanding at the same time. At most one transaction is outstanding per direction.
- Address decode uses a per-slave BASE/MASK table. An address that hits no slave gets an internal DECERR response.

Parameters:
- NSLV, 3, number of downstream slaves (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- SLV_BASE, {32'h10001000, 32'h10000000, 32'h80000000}, NSLV×AW packed base addresses; slave i occupies bits [i*AW +: AW].
- SLV_MASK, {32'hFFFFF000, 32'hFFFFFFF0, 32'hFF000000}, NSLV×AW packed masks. Slave i hits when (addr & MASK_i) == BASE_i.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_arvalid/in_arready  in/out  1  upstream AR handshake
- in_araddr  in  AW  read address
- in_rvalid/in_rready  out/in  1  upstream R handshake
- in_rdata  out  DW  read data
- in_rresp  out  2  read response
- in_awvalid/in_awready  in/out  1  upstream AW handshake
- in_awaddr  in  AW  write address
- in_wvalid/in_wready  in/out  1  upstream W handshake
- in_wdata  in  DW  write data
- in_wstrb  in  DW/8  byte strobes
- in_bvalid/in_bready  out/in  1  upstream B handshake
- in_bresp  out  2  write response
- m_arvalid/m_arready  out/in  NSLV  per-slave AR handshake
- m_araddr  out  NSLV*AW  per-slave AR address
- m_rvalid/m_rready  in/out  NSLV  per-slave R handshake
- m_rdata  in  NSLV*DW  per-slave read data
- m_rresp  in  NSLV*2  per-slave read response
- m_awvalid/m_awready  out/in  NSLV  per-slave AW handshake
- m_awaddr  out  NSLV*AW  per-slave AW address
- m_wvalid/m_wready  out/in  NSLV  per-slave W handshake
- m_wdata  out  NSLV*DW  per-slave write data
- m_wstrb  out  NSLV*DW/8  per-slave strobes
- m_bvalid/m_bready  in/out  NSLV  per-slave B handshake
- m_bresp  in  NSLV*2  per-slave write response

Behaviour:
- Decode: combinational hit vector per address. The lowest index wins on overlap. No hit means miss. The target index and a miss flag are registered on the address handshake.
- Read FSM R_IDLE → R_DATA:
  - R_IDLE: m_arvalid[t] = in_arvalid for hit t. in_arready = m_arready[t], or 1 on miss.
  - On AR fire, latch rt/rmiss and go to R_DATA.
  - R_DATA, hit: route m_rvalid/rdata/rresp[rt] to upstream and in_rready to m_rready[rt].
  - R_DATA, miss: in_rvalid = 1, rdata = 0, rresp = 2'b11.
  - On R fire, return to R_IDLE. in_arready = 0 in R_DATA.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: AW routed the same way as AR. On AW fire, latch wt/wmiss and go to W_DATA. in_wready = 0 in W_IDLE.
  - W_DATA: m_wvalid[wt] = in_wvalid and in_wready = m_wready[wt]. On miss, in_wready = 1 and nothing is forwarded. On W fire, go to W_RESP.
  - W_RESP: routes B like R. On miss, bvalid = 1 and bresp = 2'b11. On B fire, return to W_IDLE.
- All non-selected m_*valid and m_*ready are 0.
- m_araddr/m_awaddr/m_wdata/m_wstrb broadcast the upstream values to every slave.
- Upstream data/resp outputs are 0 whenever the matching valid is 0.
- Read and write FSMs never block each other. An AR and an AW in the same cycle both fire, if their slaves are ready, even when both target the same slave.
- A valid already asserted to a slave is held until its handshake completes. Upstream AXI rules are assumed, so no retraction can occur.
- Reset (rst_n = 0 at a clk edge): both FSMs go to IDLE, targets are cleared, miss flags = 0. Every output valid/ready is then 0, except in_arready/in_awready, which follow the combinational decode. Reset mid-transaction abandons it; slaves are reset by the same rst_n.
- Latency: address pass-through is zero-cycle combinational. There is one FSM cycle between phases. A miss response appears the cycle after the address fire.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - FSM state localparams for the read and write FSMs.
- One sub-module, axi_lite_addr_dec (params NSLV, AW, SLV_BASE, SLV_MASK; in addr; out idx[$clog2(NSLV)], miss). It is instantiated twice, once for AR and once for AW.

Test Plan:
- Read 0x80000010, slave0 returns rdata = 32'hDEADBEEF, OKAY after 3 wait cycles → in_rdata = DEADBEEF, in_rresp = 0; m_arvalid = 3'b001 only.
- Write 0x10000000, wdata = 0x41, wstrb = 4'b0001 → m_awvalid = 3'b010, m_wdata = 0x41, in_bresp = 0 after the slave1 bvalid.
- Read 0x20000000 → in_rvalid the cycle after AR fire, in_rresp = 2'b11, rdata = 0, no m_arvalid ever asserted. Same for a write, giving bresp = 2'b11.
- Concurrent AR to 0x10001000 and AW to 0x80000000 in the same cycle → both fire. Responses arrive in either order: R returns the slave2 data, B returns slave0 OKAY.
- in_rready held 0 for 5 cycles while m_rvalid[0] = 1 → rdata stable and m_rready[0] = 0; the next AR is not accepted until R fires.
- rst_n pulsed low in W_DATA → next cycle all m_* valids = 0, write FSM idle; a following write completes normally.
